riscv_run_controller: RTL and testbench

//  Synthesisable run controller for the pipelined RISC-V core; replaces fixed-delay bench timing.

---
 rtl/riscv_run_pkg.sv | 17 +
 rtl/sat_counter.sv | 34 +++
 rtl/riscv_run_controller.sv | 147 ++++++++++++++
 tb/tb_riscv_run_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_run_pkg.sv
// Shared types and constants for the core run controller.
package riscv_run_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_HALT     = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_DEADLOCK = 2'b11;

  localparam logic [31:0] HALT_INSN_DEF = 32'h0000_0073;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/riscv_run_controller.sv
// Run controller: sequences core reset, counts cycles and retires,
// and ends the run on halt, timeout or retire deadlock.
module riscv_run_controller
  import riscv_run_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int STALL_LIMIT  = 16,
  parameter logic [XLEN-1:0] HALT_INSN = XLEN'(HALT_INSN_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic [XLEN-1:0]  retire_insn,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic [1:0]       done_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [XLEN-1:0]  last_pc
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam longint unsigned MAX_M1 = 64'(MAX_CYCLES - 1);

  run_state_e      state_d, state_q;
  logic [1:0]      cause_d, cause_q;
  logic [XLEN-1:0] pc_d, pc_q;

  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   stall_cnt;
  logic            in_hold;
  logic            in_run;
  logic            halt_hit;
  logic            timeout_hit;
  logic            stall_hit;
  logic [1:0]      end_cause;

  assign in_hold = (state_q == HOLD);
  assign in_run  = (state_q == RUN);

  sat_counter #(.W(HW)) u_hold (
    .clk   (clk),
    .reset (reset),
    .clear (restart | ~in_hold),
    .inc   (in_hold),
    .q     (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .reset (reset),
    .clear (restart | in_hold),
    .inc   (in_run),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retire (
    .clk   (clk),
    .reset (reset),
    .clear (restart | in_hold),
    .inc   (in_run & retire_valid),
    .q     (retire_count)
  );

  sat_counter #(.W(SW)) u_stall (
    .clk   (clk),
    .reset (reset),
    .clear (restart | in_hold | (in_run & retire_valid)),
    .inc   (in_run & ~retire_valid),
    .q     (stall_cnt)
  );

  // Timeout compares the pre-increment count: this edge completes run cycle MAX_CYCLES.
  assign halt_hit    = retire_valid && (retire_insn == HALT_INSN);
  assign timeout_hit = (64'(cycle_count) == MAX_M1);
  assign stall_hit   = !retire_valid &&
                       (stall_cnt == SW'(STALL_LIMIT - 1));

  always_comb begin
    end_cause = CAUSE_NONE;
    if (halt_hit) begin
      end_cause = CAUSE_HALT;
    end else if (timeout_hit) begin
      end_cause = CAUSE_TIMEOUT;
    end else if (stall_hit) begin
      end_cause = CAUSE_DEADLOCK;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    unique case (state_q)
      HOLD: begin
        if (hold_cnt == HW'(RESET_CYCLES)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (retire_valid) begin
          pc_d = retire_pc;
        end
        if (end_cause != CAUSE_NONE) begin
          state_d = DONE;
          cause_d = end_cause;
        end
      end
      DONE: begin
      end
      default: begin
        state_d = HOLD;
      end
    endcase
    if (restart) begin
      state_d = HOLD;
      cause_d = CAUSE_NONE;
      pc_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      cause_q <= CAUSE_NONE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  assign core_reset = in_hold;
  assign running    = in_run;
  assign done       = (state_q == DONE);
  assign done_cause = cause_q;
  assign last_pc    = pc_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Scoreboard bench: two controller instances share stimulus, a
// behavioural run model predicts every registered output.
module tb_riscv_run_controller;

  localparam logic [31:0] HALT = 32'h0000_0073;

  logic        clk;
  logic        reset;
  logic        restart;
  logic        rv;
  logic [31:0] rpc;
  logic [31:0] rinsn;

  logic        a_cr, a_run, a_dn;
  logic [1:0]  a_cause;
  logic [31:0] a_cyc, a_ret, a_pc;
  logic        b_cr, b_run, b_dn;
  logic [1:0]  b_cause;
  logic [3:0]  b_cyc, b_ret;
  logic [31:0] b_pc;

  riscv_run_controller #(
    .XLEN(32), .CNT_W(32), .RESET_CYCLES(2),
    .MAX_CYCLES(10), .STALL_LIMIT(4)
  ) dut_a (
    .clk(clk), .reset(reset), .restart(restart),
    .retire_valid(rv), .retire_pc(rpc), .retire_insn(rinsn),
    .core_reset(a_cr), .running(a_run), .done(a_dn),
    .done_cause(a_cause), .cycle_count(a_cyc),
    .retire_count(a_ret), .last_pc(a_pc)
  );

  riscv_run_controller #(
    .XLEN(32), .CNT_W(4), .RESET_CYCLES(3),
    .MAX_CYCLES(100), .STALL_LIMIT(5)
  ) dut_b (
    .clk(clk), .reset(reset), .restart(restart),
    .retire_valid(rv), .retire_pc(rpc), .retire_insn(rinsn),
    .core_reset(b_cr), .running(b_run), .done(b_dn),
    .done_cause(b_cause), .cycle_count(b_cyc),
    .retire_count(b_ret), .last_pc(b_pc)
  );

  // Model keeps true (unbounded) counts; saturation applied on view.
  typedef struct {
    bit          hold;
    bit          run;
    bit          fin;
    int          held;
    longint      cyc;
    longint      ret;
    int          idle;
    int          cause;
    logic [31:0] pc;
  } mst_t;

  typedef struct {
    bit          cr;
    bit          run;
    bit          dn;
    int          cause;
    longint      cyc;
    longint      ret;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } ent_t;

  ent_t sb[$];
  mst_t ma, mb;
  int   tests;
  int   fails;

  function automatic mst_t fresh();
    mst_t n;
    n.hold = 1; n.run = 0; n.fin = 0; n.held = 0;
    n.cyc = 0; n.ret = 0; n.idle = 0; n.cause = 0;
    n.pc = '0;
    return n;
  endfunction

  function automatic mst_t step(
    mst_t m, bit rst, bit rs, bit v,
    logic [31:0] pc, logic [31:0] insn,
    int rc, int mx, int sl
  );
    mst_t n = m;
    if (rst || rs) return fresh();
    if (m.hold) begin
      if (m.held == rc) begin
        n.hold = 0;
        n.run = 1;
      end else begin
        n.held++;
      end
    end else if (m.run) begin
      n.cyc++;
      if (v) begin
        n.ret++;
        n.pc = pc;
        n.idle = 0;
      end else begin
        n.idle++;
      end
      if (v && insn == HALT) n.cause = 1;
      else if (n.cyc == mx) n.cause = 2;
      else if (n.idle == sl) n.cause = 3;
      if (n.cause != 0) begin
        n.run = 0;
        n.fin = 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t view(mst_t m, int w);
    exp_t e;
    longint cap = (64'sd1 <<< w) - 1;
    e.cr = m.hold; e.run = m.run; e.dn = m.fin;
    e.cause = m.cause; e.pc = m.pc;
    e.cyc = (m.cyc > cap) ? cap : m.cyc;
    e.ret = (m.ret > cap) ? cap : m.ret;
    return e;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(
    bit rs, bit v, logic [31:0] pc, logic [31:0] insn
  );
    ent_t e;
    restart = rs; rv = v; rpc = pc; rinsn = insn;
    ma = step(ma, reset, rs, v, pc, insn, 2, 10, 4);
    mb = step(mb, reset, rs, v, pc, insn, 3, 100, 5);
    e.a = view(ma, 32);
    e.b = view(mb, 4);
    sb.push_back(e);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_insn();
    logic [31:0] x = $urandom;
    if (x == HALT) x = x ^ 32'h1;
    return x;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Monitor: pops one prediction per edge and compares both instances.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("a.core_reset", a_cr, e.a.cr);
        chk("a.running", a_run, e.a.run);
        chk("a.done", a_dn, e.a.dn);
        chk("a.done_cause", a_cause, e.a.cause);
        chk("a.cycle_count", a_cyc, e.a.cyc);
        chk("a.retire_count", a_ret, e.a.ret);
        chk("a.last_pc", a_pc, e.a.pc);
        chk("b.core_reset", b_cr, e.b.cr);
        chk("b.running", b_run, e.b.run);
        chk("b.done", b_dn, e.b.dn);
        chk("b.done_cause", b_cause, e.b.cause);
        chk("b.cycle_count", b_cyc, e.b.cyc);
        chk("b.retire_count", b_ret, e.b.ret);
        chk("b.last_pc", b_pc, e.b.pc);
      end
    end
  end

  initial begin
    tests = 0; fails = 0;
    ma = fresh(); mb = fresh();
    reset = 1; restart = 0; rv = 0; rpc = '0; rinsn = '0;

    // reset for one edge, then hold release
    drive(0, 0, 0, 0);
    reset = 0;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);

    // halt after five retires
    for (int i = 0; i < 5; i++)
      drive(0, 1, 32'(i * 4), (i == 4) ? HALT : 32'h13);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

    // timeout with continuous non-halt retires
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) drive(0, 1, 32'(i * 4), 32'h13);

    // deadlock after two retires
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    drive(0, 1, 32'h100, 32'h13);
    drive(0, 1, 32'h104, 32'h13);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0);

    // halt on the timeout cycle, then restart in DONE
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      drive(0, 1, 32'(i * 4), (i == 9) ? HALT : 32'h13);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);

    // saturation on the narrow instance
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    for (int i = 0; i < 25; i++) drive(0, 1, 32'(i * 4), 32'h13);

    // async reset between edges during run cycle 7
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 32'(i * 4 + 8), 32'h13);
    reset = 1;
    #1;
    chk("async.core_reset", a_cr, 1);
    chk("async.running", a_run, 0);
    chk("async.done", a_dn, 0);
    chk("async.cause", a_cause, 0);
    chk("async.cycle_count", a_cyc, 0);
    chk("async.retire_count", a_ret, 0);
    chk("async.last_pc", a_pc, 0);
    chk("async.b_cycle_count", b_cyc, 0);
    ma = fresh(); mb = fresh();
    drive(0, 1, 32'h40, 32'h13);
    reset = 0;

    // randomized runs with occasional restarts
    for (int s = 0; s < 25; s++) begin
      int n = $urandom_range(5, 45);
      drive(1, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
        bit v = ($urandom % 4) != 0;
        bit h = ($urandom % 64) == 0;
        bit r = ($urandom % 50) == 0;
        logic [31:0] pc = {$urandom, 2'b00};
        drive(r, v, pc, h ? HALT : rnd_insn());
      end
    end

    #2;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left expected 0",
               sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
